// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: drives next-PC, runs the imem req/ack handshake and owns IF/ID.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_wait counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_INC       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
`endif
);

  typedef enum logic [0:0] {StReq, StHold} state_e;

  state_e      state_q;
  logic        pend_valid_q;
  logic [31:0] pend_target_q;
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc4_q;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus;

  // Branch resolves in EX, so it belongs to an older instruction than an ID jump.
  assign redirect        = branch_taken | jump;
  assign redirect_target = branch_taken ? branch_target : jump_target;
  assign pc_plus         = pc_in + 32'(PC_INC);
  assign imem_addr       = pc_in;

  always_comb begin
    pc_next  = pc_in;
    imem_req = 1'b0;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else begin
      unique case (state_q)
        StReq: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            if (redirect)          pc_next = redirect_target;
            else if (pend_valid_q) pc_next = pend_target_q;
            else                   pc_next = pc_plus;
          end
        end
        StHold: begin
          if (redirect) pc_next = redirect_target;
        end
        default: pc_next = pc_in;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StReq;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      hold_instr_q  <= '0;
      hold_pc4_q    <= '0;
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
    end else begin
      unique case (state_q)
        StReq: begin
          if (!imem_ack) begin
            // Address must stay stable until ack, so a redirect is parked until then.
            if (redirect) begin
              pend_valid_q  <= 1'b1;
              pend_target_q <= redirect_target;
              ifid_valid    <= 1'b0;
            end else if (!stall) begin
              ifid_valid <= 1'b0;
            end
          end else if (redirect || pend_valid_q) begin
            pend_valid_q <= 1'b0;
            ifid_valid   <= 1'b0;
          end else if (!stall) begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= imem_rdata;
            ifid_pc_plus4 <= pc_plus;
          end else begin
            hold_instr_q <= imem_rdata;
            hold_pc4_q   <= pc_plus;
            state_q      <= StHold;
          end
        end
        StHold: begin
          if (redirect) begin
            ifid_valid <= 1'b0;
            state_q    <= StReq;
          end else if (!stall) begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= hold_instr_q;
            ifid_pc_plus4 <= hold_pc4_q;
            state_q       <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_load;
  logic wait_cycle;

  assign fetch_load = ((state_q == StReq) && imem_ack && !redirect && !pend_valid_q && !stall) ||
                      ((state_q == StHold) && !redirect && !stall);
  assign wait_cycle = (state_q == StReq) && !imem_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_wait    <= '0;
    end else begin
      if (fetch_load) perf_fetched <= perf_fetched + 32'd1;
      if (wait_cycle) perf_wait    <= perf_wait + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule
